// File: rtl/requant_relu_if.sv
// Stream interface between the PE array, the requant/ReLU stage and the pooling write port.
// The bias field exists only when REQUANT_BIAS_EN is defined.
interface requant_relu_if #(
    parameter int PSUM_BITWIDTH    = 32,
    parameter int DATA_BITWIDTH    = 8,
    parameter int ADDRESS_BITWIDTH = 12,
    parameter int SHIFT_BITWIDTH   = 5
) ();
    logic                               enable;
    logic                               set_info;
    logic        [ADDRESS_BITWIDTH-1:0] e_size;
    logic        [ADDRESS_BITWIDTH-1:0] f_size;
    logic        [SHIFT_BITWIDTH-1:0]   shift;
    logic                               relu;
`ifdef REQUANT_BIAS_EN
    logic signed [PSUM_BITWIDTH-1:0]    bias;
`endif
    logic signed [PSUM_BITWIDTH-1:0]    psum_in;
    logic                               psum_valid;
    logic                               psum_ready;
    logic signed [DATA_BITWIDTH-1:0]    data_out;
    logic        [ADDRESS_BITWIDTH-1:0] e_out;
    logic        [ADDRESS_BITWIDTH-1:0] f_out;
    logic                               out_valid;
    logic                               out_ready;
    logic                               busy;
    logic                               done;

    modport slave (
        input  enable, set_info, e_size, f_size, shift, relu,
`ifdef REQUANT_BIAS_EN
        input  bias,
`endif
        input  psum_in, psum_valid, out_ready,
        output psum_ready, data_out, e_out, f_out, out_valid, busy, done
    );

    modport master (
        output enable, set_info, e_size, f_size, shift, relu,
`ifdef REQUANT_BIAS_EN
        output bias,
`endif
        output psum_in, psum_valid, out_ready,
        input  psum_ready, data_out, e_out, f_out, out_valid, busy, done
    );
endinterface

// File: rtl/requant_relu.sv
// Requantization stage: rounding right shift, optional ReLU, saturation, raster (e,f) tagging.
// Define REQUANT_BIAS_EN to add a per-frame bias that is summed in before the shift.
module requant_relu #(
    parameter int PSUM_BITWIDTH    = 32,
    parameter int DATA_BITWIDTH    = 8,
    parameter int ADDRESS_BITWIDTH = 12,
    parameter int SHIFT_BITWIDTH   = 5
) (
    input  logic           clk,
    input  logic           rst,
    requant_relu_if.slave  bus
);

    localparam int SUM_W = PSUM_BITWIDTH + 2;
    localparam int CNT_W = 2 * ADDRESS_BITWIDTH;
    localparam logic        [CNT_W-1:0]            CNT_ONE  = CNT_W'(1);
    localparam logic        [ADDRESS_BITWIDTH-1:0] ADDR_ONE = ADDRESS_BITWIDTH'(1);
    localparam logic signed [SUM_W-1:0]            MAX_V    = SUM_W'((2 ** (DATA_BITWIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0]            MIN_V    = ~MAX_V;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic        [ADDRESS_BITWIDTH-1:0] r_eSize;
    logic        [ADDRESS_BITWIDTH-1:0] r_fSize;
    logic        [SHIFT_BITWIDTH-1:0]   r_shift;
    logic                               r_relu;
    logic        [CNT_W-1:0]            r_total;
    logic        [CNT_W-1:0]            r_inCount;
    logic        [ADDRESS_BITWIDTH-1:0] r_eOut;
    logic        [ADDRESS_BITWIDTH-1:0] r_fOut;
`ifdef REQUANT_BIAS_EN
    logic signed [PSUM_BITWIDTH-1:0]    r_bias;
`endif

    logic                               r_s1Valid;
    logic signed [SUM_W-1:0]            r_s1Val;
    logic                               r_s2Valid;
    logic signed [DATA_BITWIDTH-1:0]    r_dataOut;

    logic                               w_cfgLoad;
    logic                               w_outFire;
    logic                               w_s2Adv;
    logic                               w_s1Adv;
    logic                               w_psumReady;
    logic                               w_inFire;
    logic                               w_lastCol;
    logic                               w_lastPix;
    logic signed [SUM_W-1:0]            w_round;
    logic signed [SUM_W-1:0]            w_bias;
    logic signed [SUM_W-1:0]            w_sum;
    logic signed [SUM_W-1:0]            w_shifted;
    logic signed [DATA_BITWIDTH-1:0]    w_sat;

    assign w_cfgLoad   = (r_state == IDLE) && bus.enable && bus.set_info;
    assign w_outFire   = bus.enable && r_s2Valid && bus.out_ready;
    assign w_s2Adv     = bus.enable && (!r_s2Valid || bus.out_ready);
    assign w_s1Adv     = bus.enable && (!r_s1Valid || w_s2Adv);
    assign w_psumReady = (r_state == RUN) && (r_inCount < r_total) && w_s1Adv;
    assign w_inFire    = bus.psum_valid && w_psumReady;
    assign w_lastCol   = (r_fOut == (r_fSize - ADDR_ONE));
    assign w_lastPix   = w_lastCol && (r_eOut == (r_eSize - ADDR_ONE));

`ifdef REQUANT_BIAS_EN
    assign w_bias = SUM_W'(r_bias);
`else
    assign w_bias = '0;
`endif

    // Two guard bits keep psum + bias + half-LSB from overflowing before the shift.
    assign w_round   = (r_shift == '0) ? '0 : (SUM_W'(1) <<< (r_shift - 1'b1));
    assign w_sum     = SUM_W'(bus.psum_in) + w_bias + w_round;
    assign w_shifted = w_sum >>> r_shift;

    always_comb begin
        w_sat = r_s1Val[DATA_BITWIDTH-1:0];
        if (r_relu && (r_s1Val < 0)) begin
            w_sat = '0;
        end else if (r_s1Val > MAX_V) begin
            w_sat = MAX_V[DATA_BITWIDTH-1:0];
        end else if (r_s1Val < MIN_V) begin
            w_sat = MIN_V[DATA_BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_cfgLoad) w_nextState = RUN;
            RUN:     if (w_outFire && w_lastPix) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Frame configuration is only captured from IDLE, so a stray set_info mid-frame is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eSize <= '0;
            r_fSize <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_total <= '0;
`ifdef REQUANT_BIAS_EN
            r_bias  <= '0;
`endif
        end else if (w_cfgLoad) begin
            r_eSize <= bus.e_size;
            r_fSize <= bus.f_size;
            r_shift <= bus.shift;
            r_relu  <= bus.relu;
            r_total <= CNT_W'(bus.e_size) * CNT_W'(bus.f_size);
`ifdef REQUANT_BIAS_EN
            r_bias  <= bus.bias;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inCount <= '0;
            r_eOut    <= '0;
            r_fOut    <= '0;
        end else if (w_cfgLoad) begin
            r_inCount <= '0;
            r_eOut    <= '0;
            r_fOut    <= '0;
        end else begin
            if (w_inFire) begin
                r_inCount <= r_inCount + CNT_ONE;
            end
            if (w_outFire && (r_state == RUN)) begin
                if (w_lastPix) begin
                    r_eOut <= '0;
                    r_fOut <= '0;
                end else if (w_lastCol) begin
                    r_eOut <= r_eOut + ADDR_ONE;
                    r_fOut <= '0;
                end else begin
                    r_fOut <= r_fOut + ADDR_ONE;
                end
            end
        end
    end

    // Each stage loads when it is empty or its content leaves in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            r_s1Val   <= '0;
            r_s2Valid <= 1'b0;
            r_dataOut <= '0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= w_inFire;
                if (w_inFire) begin
                    r_s1Val <= w_shifted;
                end
            end
            if (w_s2Adv) begin
                r_s2Valid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_dataOut <= w_sat;
                end
            end
        end
    end

    assign bus.psum_ready = w_psumReady;
    assign bus.out_valid  = r_s2Valid;
    assign bus.data_out   = r_dataOut;
    assign bus.e_out      = r_eOut;
    assign bus.f_out      = r_fOut;
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);

endmodule

// File: tb/tb_requant_relu.sv
// Scoreboard bench for requant_relu: directed frames, expected pixels queued at psum handshake.
// Covers REQUANT_BIAS_EN when that macro is defined for the build.
module tb_requant_relu;

    typedef struct {
        int d;
        int e;
        int f;
    } exp_t;

    logic clk;
    logic rst;

    requant_relu_if bus ();

    requant_relu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   numChecks = 0;
    int   numFails  = 0;
    int   cycle     = 0;
    int   doneCount = 0;
    int   doneBase  = 0;
    int   hsCycle   = -1;
    int   validCycle = -1;
    bit   measure   = 1'b0;

    bit   prevHold  = 1'b0;
    int   prevData, prevE, prevF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Global time limit so a stuck handshake can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached (got timeout expected finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            prevHold = 1'b0;
        end else begin
            if (bus.done) doneCount++;
            if (measure && validCycle < 0 && bus.out_valid) validCycle = cycle;
            if (prevHold) begin
                checkOutput("hold_valid", int'(bus.out_valid), 1);
                checkOutput("hold_data", int'($signed(bus.data_out)), prevData);
                checkOutput("hold_e", int'(bus.e_out), prevE);
                checkOutput("hold_f", int'(bus.f_out), prevF);
            end
            if (bus.out_valid && bus.out_ready && bus.enable) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    checkOutput("data_out", int'($signed(bus.data_out)), x.d);
                    checkOutput("e_out", int'(bus.e_out), x.e);
                    checkOutput("f_out", int'(bus.f_out), x.f);
                end
            end
            prevHold = bus.out_valid && !(bus.out_ready && bus.enable);
            prevData = int'($signed(bus.data_out));
            prevE    = int'(bus.e_out);
            prevF    = int'(bus.f_out);
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic startFrame(input int e, input int f, input int sh, input bit rl, input int bs);
        bus.e_size   = 12'(e);
        bus.f_size   = 12'(f);
        bus.shift    = 5'(sh);
        bus.relu     = rl;
`ifdef REQUANT_BIAS_EN
        bus.bias     = bs;
`else
        if (bs != 0) $display("[TB] bias %0d ignored without REQUANT_BIAS_EN", bs);
`endif
        bus.set_info = 1'b1;
        doneBase     = doneCount;
        @(posedge clk); #1;
        bus.set_info = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_set_info", int'(bus.busy), 1);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int p, input int d, input int e, input int f);
        int waitCnt = 0;
        bus.psum_in    = p;
        bus.psum_valid = 1'b1;
        @(negedge clk);
        while (!bus.psum_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.psum_ready) begin
            checkOutput("psum_ready_timeout", 0, 1);
        end else begin
            q.push_back('{d: d, e: e, f: f});
            if (measure && hsCycle < 0) hsCycle = cycle;
        end
        @(posedge clk); #1;
    endtask

    task automatic waitDone(input string name);
        int waitCnt = 0;
        while (doneCount == doneBase && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_done_pulses"}, doneCount - doneBase, 1);
        checkOutput({name, "_busy_after"}, int'(bus.busy), 0);
        checkOutput({name, "_queue_drained"}, q.size(), 0);
        @(posedge clk); #1;
    endtask

    int basicP[6] = '{16, 24, -24, 40, 2047, -4000};
    int basicD[6] = '{1, 2, -1, 3, 127, -128};
    int reluP[4]  = '{3, -3, 1, 0};
    int reluD[4]  = '{2, 0, 1, 0};

    initial begin
        rst            = 1'b0;
        bus.enable     = 1'b1;
        bus.set_info   = 1'b0;
        bus.e_size     = '0;
        bus.f_size     = '0;
        bus.shift      = '0;
        bus.relu       = 1'b0;
`ifdef REQUANT_BIAS_EN
        bus.bias       = '0;
`endif
        bus.psum_in    = '0;
        bus.psum_valid = 1'b0;
        bus.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_psum_ready", int'(bus.psum_ready), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_data_out", int'(bus.data_out), 0);
        checkOutput("rst_e_out", int'(bus.e_out), 0);
        checkOutput("rst_f_out", int'(bus.f_out), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic frame 2x3 shift 4");
        measure = 1'b1;
        startFrame(2, 3, 4, 1'b0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(basicP[i], basicD[i], i / 3, i % 3);
        bus.psum_valid = 1'b0;
        waitDone("basic");
        checkOutput("latency", validCycle - hsCycle, 2);
        measure = 1'b0;

        $display("[TB] relu/rounding 1x4 shift 1, set_info mid-frame");
        startFrame(1, 4, 1, 1'b1, 0);
        applyStimulus(reluP[0], reluD[0], 0, 0);
        applyStimulus(reluP[1], reluD[1], 0, 1);
        bus.e_size = 12'd5; bus.f_size = 12'd5; bus.shift = 5'd0; bus.relu = 1'b0;
        bus.set_info = 1'b1;
        applyStimulus(reluP[2], reluD[2], 0, 2);
        bus.set_info = 1'b0;
        applyStimulus(reluP[3], reluD[3], 0, 3);
        bus.psum_valid = 1'b0;
        waitDone("relu");

        $display("[TB] shift 0 saturation 1x2");
        startFrame(1, 2, 0, 1'b0, 0);
        applyStimulus(127, 127, 0, 0);
        applyStimulus(128, 127, 0, 1);
        bus.psum_valid = 1'b0;
        waitDone("shift0");

        $display("[TB] single pixel frame");
        startFrame(1, 1, 0, 1'b0, 0);
        applyStimulus(5, 5, 0, 0);
        bus.psum_in = 99;
        @(negedge clk);
        checkOutput("single_extra_ready", int'(bus.psum_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("single_extra_ready2", int'(bus.psum_ready), 0);
        @(posedge clk); #1;
        waitDone("single");
        bus.psum_valid = 1'b0;

        $display("[TB] backpressure 2x4");
        startFrame(2, 4, 0, 1'b0, 0);
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(i, i, i / 4, i % 4);
                bus.psum_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    bus.out_ready = (k % 2 == 0);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 3) begin
                        checkOutput("bp_ready_when_full", int'(bus.psum_ready), 0);
                        checkOutput("bp_valid_when_full", int'(bus.out_valid), 1);
                    end
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        waitDone("backpressure");

        $display("[TB] enable freeze 1x3");
        startFrame(1, 3, 0, 1'b0, 0);
        fork
            begin
                applyStimulus(10, 10, 0, 0);
                applyStimulus(20, 20, 0, 1);
                applyStimulus(30, 30, 0, 2);
                bus.psum_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus.enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("en_low_psum_ready", int'(bus.psum_ready), 0);
                    checkOutput("en_low_busy", int'(bus.busy), 1);
                    @(posedge clk); #1;
                end
                bus.enable = 1'b1;
            end
        join
        waitDone("enable");

        $display("[TB] reset mid-frame");
        startFrame(2, 2, 0, 1'b0, 0);
        bus.out_ready = 1'b0;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(2, 2, 0, 1);
        bus.psum_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
        checkOutput("midrst_psum_ready", int'(bus.psum_ready), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_e_out", int'(bus.e_out), 0);
        checkOutput("midrst_f_out", int'(bus.f_out), 0);
        checkOutput("midrst_data_out", int'(bus.data_out), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;

`ifdef REQUANT_BIAS_EN
        $display("[TB] bias frame 1x2");
        startFrame(1, 2, 2, 1'b0, -8);
        applyStimulus(8, 0, 0, 0);
        applyStimulus(40, 8, 0, 1);
        bus.psum_valid = 1'b0;
        waitDone("bias");
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
